vend_request_frontend: RTL and testbench
========================================

# vend_request_frontend

Upstream front-end for `head_module`. It accepts coin strobes, accumulates customer credit up to 15 units, and handles cancel and inactivity timeout by issuing a refund. On a product selection it emits a one-cycle `costumer_mode` request carrying `product` and `costumer_money`, which connect directly to the matching `head_module` inputs.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 200: idle cycles in COLLECT before automatic refund; legal range 2..65535.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `coin_valid`  in  1  one-cycle strobe: a coin has been inserted.
- `coin_value`  in  3  coin value, 1..7; value 0 is invalid.
- `select_valid`  in  1  one-cycle strobe: the customer selected a product.
- `select_product`  in  3  product code, sampled with `select_valid`.
- `cancel`  in  1  one-cycle strobe: the customer requests a refund.
- `costumer_mode`  out  1  one-cycle purchase request to `head_module`.
- `product`  out  3  product code of the last issued request.
- `costumer_money`  out  4  credit of the last issued request.
- `credit`  out  4  live accumulated credit, used by the display path.
- `coin_reject`  out  1  one-cycle pulse: the coin was returned and not credited.
- `refund_valid`  out  1  one-cycle refund pulse.
- `refund_amount`  out  4  value of the last refund.

## Operation
- Reset state: FSM in IDLE. Every output is 0, including `product`, `costumer_money`, `credit` and `refund_amount`. The timeout counter is 0. Credit held at reset is discarded and no refund pulse is issued.
- FSM states:
  - IDLE: credit is 0.
  - COLLECT: credit is greater than 0.
  - ISSUE: single cycle.
  - REFUND: single cycle.
- Coin acceptance, evaluated in IDLE and COLLECT:
  - A coin is accepted when `coin_value` != 0 and `credit + coin_value` <= 15, computed at 5-bit width.
  - Accepted coin: `credit` += `coin_value`, timeout counter resets to 0, state becomes COLLECT.
  - Otherwise: `coin_reject` pulses, credit is unchanged, and the timeout counter is not reset.
- Select handling:
  - In COLLECT: go to ISSUE. During ISSUE, `costumer_mode`=1, `product`=`select_product` as sampled, `costumer_money`=credit, and `credit` goes to 0. Next state is IDLE.
  - In IDLE: ignored; no output change.
- Cancel handling:
  - In COLLECT: go to REFUND. During REFUND, `refund_valid`=1, `refund_amount`=credit, and `credit` goes to 0. Next state is IDLE.
  - In IDLE: ignored.
- Timeout:
  - In COLLECT, the counter increments every cycle in which no coin is accepted and there is no select or cancel.
  - When the counter equals `TIMEOUT_CYCLES-1`, the FSM goes to REFUND, exactly as for cancel.
- Priority within a single cycle: cancel > select > timeout > coin.
  - A coin arriving in the same cycle as any winning event is rejected (`coin_reject` pulses).
  - A coin arriving while in ISSUE or REFUND is rejected.
  - A select or cancel arriving while in ISSUE or REFUND is ignored.
- Hold behaviour: `product`, `costumer_money` and `refund_amount` keep their last values until the next ISSUE or REFUND overwrites them.

## Timing
- All outputs are registered.
- Accepted coin at edge N: `credit` is updated after edge N. `coin_reject` pulses for the cycle after edge N.
- `select_valid` sampled at edge N: `costumer_mode`, `product` and `costumer_money` are valid after edge N. `credit` reads 0 in that same cycle. `costumer_mode` falls after edge N+1. Latency is 1 cycle.
- Cancel and timeout follow the same pattern, with 1-cycle latency on `refund_valid`.
- Timeout: the last activity at edge N produces `refund_valid` after edge N+`TIMEOUT_CYCLES`.
- The earliest new coin is accepted at the edge after ISSUE or REFUND, because the FSM is in IDLE by then.
- `rst_n` low clears all state immediately, without waiting for a clock edge. Release is synchronous to the next `clk` edge.

## Test plan
1. Reset, then coins of 5 and 5 on consecutive cycles, then select 3'b010 → `credit` reads 5 then 10. `costumer_mode` is high for exactly 1 cycle with `product`=2 and `costumer_money`=10. `credit`=0 afterwards.
2. Credit 12, then coin 4 → `coin_reject` pulse and `credit` stays 12. Next, coin 3 → `credit`=15. Next, coin 1 → rejected.
3. Credit 7, then `cancel` → `refund_valid` 1 cycle with `refund_amount`=7, then IDLE. A subsequent select produces no `costumer_mode`.
4. `TIMEOUT_CYCLES`=10, coin 6, then no activity → `refund_valid` exactly 10 cycles after the coin edge with `refund_amount`=6. A rejected coin in between does not extend the timeout.
5. Credit 9, then `cancel`, `select_valid` and `coin_valid` (value 2) all in the same cycle → refund of 9 and `coin_reject`, with no `costumer_mode`. Repeat with select and coin only → `costumer_mode` with `costumer_money`=9 and `coin_reject`.
6. Credit 11, then `rst_n` pulsed low between edges → all outputs 0 immediately, with no `refund_valid` pulse. Coin 0 while in IDLE → `coin_reject` and the FSM stays in IDLE.

Source files
------------

// File: rtl/vend_request_frontend.sv
// vend_request_frontend: coin/credit front-end that issues purchase requests and refunds
//
// Collects coin strobes into a credit of at most 15 units. A selection while
// collecting emits a one-cycle purchase request toward head_module; a cancel
// or an inactivity timeout emits a one-cycle refund of the held credit.
//
// Ports:
//   clk_i              system clock, rising edge
//   rst_ni             asynchronous active-low reset
//   coin_valid_i       one-cycle coin strobe
//   coin_value_i[2:0]  coin value 1..7 (0 is invalid and always rejected)
//   select_valid_i     one-cycle product selection strobe
//   select_product_i   product code sampled with select_valid_i
//   cancel_i           one-cycle refund request strobe
//   costumer_mode_o    one-cycle purchase request to head_module
//   product_o          product code of the last issued request
//   costumer_money_o   credit carried by the last issued request
//   credit_o           live accumulated credit
//   coin_reject_o      one-cycle pulse: the coin was not credited
//   refund_valid_o     one-cycle refund pulse
//   refund_amount_o    value of the last refund
module vend_request_frontend #(
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       coin_valid_i,
    input  logic [2:0] coin_value_i,
    input  logic       select_valid_i,
    input  logic [2:0] select_product_i,
    input  logic       cancel_i,
    output logic       costumer_mode_o,
    output logic [2:0] product_o,
    output logic [3:0] costumer_money_o,
    output logic [3:0] credit_o,
    output logic       coin_reject_o,
    output logic       refund_valid_o,
    output logic [3:0] refund_amount_o
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] ISSUE   = 2'd2;
    localparam logic [1:0] REFUND  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  credit_q, credit_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic [2:0]  product_q, product_d;
    logic [3:0]  money_q, money_d;
    logic        reject_q, reject_d;
    logic        refund_q, refund_d;
    logic [3:0]  ramt_q, ramt_d;

    logic        collect, timeout, win, open, accept;
    logic [4:0]  sum;

    always_comb begin
        collect   = state_q == COLLECT;
        timeout   = cnt_q == 16'(TIMEOUT_CYCLES - 1);
        // cancel, select and timeout only matter while collecting
        win       = collect && (cancel_i || select_valid_i || timeout);
        open      = state_q == IDLE || collect;
        // 5-bit sum so an overflowing coin is seen as > 15 rather than wrapping
        sum       = {1'b0, credit_q} + {2'b00, coin_value_i};
        accept    = coin_valid_i && coin_value_i != 3'd0 && sum <= 5'd15 && open && !win;
        mode_d    = collect && !cancel_i && select_valid_i;
        refund_d  = collect && (cancel_i || (!select_valid_i && timeout));
        state_d   = refund_d ? REFUND :
                    mode_d   ? ISSUE :
                    accept   ? COLLECT :
                    open     ? state_q : IDLE;
        credit_d  = win ? 4'd0 : accept ? sum[3:0] : credit_q;
        // a rejected coin does not restart the inactivity window
        cnt_d     = (collect && !win) ? (accept ? 16'd0 : cnt_q + 16'd1) : 16'd0;
        product_d = mode_d ? select_product_i : product_q;
        money_d   = mode_d ? credit_q : money_q;
        ramt_d    = refund_d ? credit_q : ramt_q;
        reject_d  = coin_valid_i && !accept;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            credit_q  <= 4'd0;
            cnt_q     <= 16'd0;
            mode_q    <= 1'b0;
            product_q <= 3'd0;
            money_q   <= 4'd0;
            reject_q  <= 1'b0;
            refund_q  <= 1'b0;
            ramt_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            product_q <= product_d;
            money_q   <= money_d;
            reject_q  <= reject_d;
            refund_q  <= refund_d;
            ramt_q    <= ramt_d;
        end
    end

    assign costumer_mode_o  = mode_q;
    assign product_o        = product_q;
    assign costumer_money_o = money_q;
    assign credit_o         = credit_q;
    assign coin_reject_o    = reject_q;
    assign refund_valid_o   = refund_q;
    assign refund_amount_o  = ramt_q;
endmodule

// File: tb/tb_vend_request_frontend.sv
// tb_vend_request_frontend: directed and random checks against a credit-level reference model
module tb_vend_request_frontend;
    localparam int T = 10;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       coin_valid_i = 1'b0;
    logic [2:0] coin_value_i = 3'd0;
    logic       select_valid_i = 1'b0;
    logic [2:0] select_product_i = 3'd0;
    logic       cancel_i = 1'b0;
    logic       costumer_mode_o;
    logic [2:0] product_o;
    logic [3:0] costumer_money_o;
    logic [3:0] credit_o;
    logic       coin_reject_o;
    logic       refund_valid_o;
    logic [3:0] refund_amount_o;

    vend_request_frontend #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .coin_valid_i(coin_valid_i),
        .coin_value_i(coin_value_i),
        .select_valid_i(select_valid_i),
        .select_product_i(select_product_i),
        .cancel_i(cancel_i),
        .costumer_mode_o(costumer_mode_o),
        .product_o(product_o),
        .costumer_money_o(costumer_money_o),
        .credit_o(credit_o),
        .coin_reject_o(coin_reject_o),
        .refund_valid_o(refund_valid_o),
        .refund_amount_o(refund_amount_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: credit held, cycles since last accepted coin, and
    // whether the previous cycle emitted a request/refund (machine busy).
    int m_credit, m_idle, m_prod, m_money, m_ramt;
    bit m_busy, m_mode, m_ref, m_rej;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".credit"}, {28'd0, credit_o}, m_credit);
        check({tag, ".mode"}, {31'd0, costumer_mode_o}, {31'd0, m_mode});
        check({tag, ".product"}, {29'd0, product_o}, m_prod);
        check({tag, ".money"}, {28'd0, costumer_money_o}, m_money);
        check({tag, ".reject"}, {31'd0, coin_reject_o}, {31'd0, m_rej});
        check({tag, ".refund"}, {31'd0, refund_valid_o}, {31'd0, m_ref});
        check({tag, ".ramt"}, {28'd0, refund_amount_o}, m_ramt);
    endtask

    task automatic model_reset();
        m_credit = 0; m_idle = 0; m_prod = 0; m_money = 0; m_ramt = 0;
        m_busy = 0; m_mode = 0; m_ref = 0; m_rej = 0;
    endtask

    task automatic model_step(input bit cv, input int val, input bit sv, input int sp, input bit cn);
        bit ev;
        bit fits;
        m_mode = 0; m_ref = 0; m_rej = 0;
        fits = cv && val != 0 && m_credit + val <= 15;
        if (m_busy) begin
            m_busy = 0; m_rej = cv; m_idle = 0;
        end else if (m_credit > 0) begin
            ev = cn || sv || m_idle == T - 1;
            if (cn || (!sv && m_idle == T - 1)) begin
                m_ref = 1; m_ramt = m_credit;
            end else if (sv) begin
                m_mode = 1; m_prod = sp; m_money = m_credit;
            end
            if (ev) begin
                m_credit = 0; m_busy = 1; m_rej = cv; m_idle = 0;
            end else if (fits) begin
                m_credit += val; m_idle = 0;
            end else begin
                m_rej = cv; m_idle++;
            end
        end else if (fits) begin
            m_credit += val; m_idle = 0;
        end else begin
            m_rej = cv;
        end
    endtask

    task automatic step(input string tag, input bit cv, input int val, input bit sv, input int sp, input bit cn);
        coin_valid_i = cv; coin_value_i = val[2:0];
        select_valid_i = sv; select_product_i = sp[2:0]; cancel_i = cn;
        @(posedge clk_i);
        #1;
        coin_valid_i = 0; select_valid_i = 0; cancel_i = 0;
        model_step(cv, val, sv, sp, cn);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_all("reset");
        rst_ni = 1;
        // 1: two coins of 5, then select product 2
        step("p1c1", 1, 5, 0, 0, 0); check("p1_credit5", {28'd0, credit_o}, 5);
        step("p1c2", 1, 5, 0, 0, 0); check("p1_credit10", {28'd0, credit_o}, 10);
        step("p1sel", 0, 0, 1, 2, 0);
        check("p1_mode", {31'd0, costumer_mode_o}, 1);
        check("p1_money", {28'd0, costumer_money_o}, 10);
        check("p1_prod", {29'd0, product_o}, 2);
        step("p1post", 0, 0, 0, 0, 0); check("p1_mode_low", {31'd0, costumer_mode_o}, 0);
        // 2: overflow rejection at the 15 boundary
        step("p2c7", 1, 7, 0, 0, 0);
        step("p2c5", 1, 5, 0, 0, 0);
        step("p2c4", 1, 4, 0, 0, 0); check("p2_rej4", {31'd0, coin_reject_o}, 1);
        step("p2c3", 1, 3, 0, 0, 0); check("p2_credit15", {28'd0, credit_o}, 15);
        step("p2c1", 1, 1, 0, 0, 0); check("p2_rej1", {31'd0, coin_reject_o}, 1);
        step("p2cn", 0, 0, 0, 0, 1); check("p2_ramt15", {28'd0, refund_amount_o}, 15);
        step("p2post", 0, 0, 0, 0, 0);
        // 3: cancel, then selects in REFUND and IDLE are ignored
        step("p3c7", 1, 7, 0, 0, 0);
        step("p3cn", 0, 0, 0, 0, 1);
        check("p3_ref", {31'd0, refund_valid_o}, 1);
        check("p3_ramt", {28'd0, refund_amount_o}, 7);
        step("p3s1", 0, 0, 1, 4, 0); check("p3_nomode1", {31'd0, costumer_mode_o}, 0);
        step("p3s2", 0, 0, 1, 4, 0); check("p3_nomode2", {31'd0, costumer_mode_o}, 0);
        // 4: timeout exactly T cycles after the coin, rejected coin does not extend it
        step("p4c6", 1, 6, 0, 0, 0);
        for (int i = 1; i <= T; i++) begin
            step("p4wait", i == 4, 0, 0, 0, 0);
            check("p4_ref_at", {31'd0, refund_valid_o}, {31'd0, i == T});
        end
        check("p4_ramt", {28'd0, refund_amount_o}, 6);
        step("p4post", 0, 0, 0, 0, 0);
        // 5: same-cycle priority
        step("p5c4", 1, 4, 0, 0, 0);
        step("p5c5", 1, 5, 0, 0, 0);
        step("p5all", 1, 2, 1, 5, 1);
        check("p5_ref", {31'd0, refund_valid_o}, 1);
        check("p5_ramt", {28'd0, refund_amount_o}, 9);
        check("p5_rej", {31'd0, coin_reject_o}, 1);
        check("p5_nomode", {31'd0, costumer_mode_o}, 0);
        step("p5post", 0, 0, 0, 0, 0);
        step("p5d4", 1, 4, 0, 0, 0);
        step("p5d5", 1, 5, 0, 0, 0);
        step("p5sc", 1, 2, 1, 6, 0);
        check("p5_mode", {31'd0, costumer_mode_o}, 1);
        check("p5_money", {28'd0, costumer_money_o}, 9);
        check("p5_rej2", {31'd0, coin_reject_o}, 1);
        step("p5post2", 0, 0, 0, 0, 0);
        // 6: asynchronous reset mid-cycle
        step("p6c7", 1, 7, 0, 0, 0);
        step("p6c4", 1, 4, 0, 0, 0); check("p6_credit11", {28'd0, credit_o}, 11);
        #2 rst_ni = 0;
        #1;
        model_reset();
        check_all("p6_async");
        rst_ni = 1;
        step("p6post", 0, 0, 0, 0, 0);
        step("p6c0", 1, 0, 0, 0, 0);
        check("p6_rej0", {31'd0, coin_reject_o}, 1);
        step("p6idle", 1, 3, 0, 0, 0); check("p6_credit3", {28'd0, credit_o}, 3);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                for (int j = 0; j < T + 2; j++) step("rnd_quiet", 0, 0, 0, 0, 0);
            end else begin
                step("rnd", $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                     $urandom_range(0, 15) == 0, $urandom_range(0, 7), $urandom_range(0, 19) == 0);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
